// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative shifter and valid/ready handshake
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCt,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
);

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b10000;
    localparam logic [4:0] OP_SRL = 5'b11000;
    localparam logic [4:0] OP_SRA = 5'b11001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_t;

    state_t           state;
    shift_t           shkind;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] shreg;

    logic             accept;
    logic             is_shift;
    shift_t           new_kind;
    logic [4:0]       shift_n;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shift_next;
    logic             lt;

    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign shift_n   = in_a[4:0];

    always_comb begin
        is_shift = 1'b0;
        new_kind = SH_LL;
        case (ALUCt)
            OP_SLL: begin is_shift = 1'b1; new_kind = SH_LL; end
            OP_SRL: begin is_shift = 1'b1; new_kind = SH_RL; end
            OP_SRA: begin is_shift = 1'b1; new_kind = SH_RA; end
            default: ;
        endcase
    end

    // Sign only steers the SLT comparison; everything else is sign-agnostic
    always_comb begin
        lt = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
        case (ALUCt)
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_ADD:  alu_res = in_a + in_b;
            OP_SUB:  alu_res = in_a - in_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_XOR:  alu_res = in_a ^ in_b;
            default: alu_res = in_a + in_b;
        endcase
    end

    always_comb begin
        case (shkind)
            SH_RL:   shift_next = {1'b0, shreg[WIDTH-1:1]};
            SH_RA:   shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            default: shift_next = {shreg[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shkind     <= SH_LL;
            cnt        <= 5'd0;
            shreg      <= '0;
            out_result <= '0;
            out_zero   <= 1'b1;
        end else if (flush) begin
            // result registers keep their last value; only the handshake is killed
            state <= IDLE;
            cnt   <= 5'd0;
        end else if (accept) begin
            if (is_shift) begin
                shreg  <= in_b;
                shkind <= new_kind;
                cnt    <= shift_n;
                if (shift_n == 5'd0) begin
                    out_result <= in_b;
                    out_zero   <= (in_b == '0);
                    state      <= DONE;
                end else begin
                    state <= SHIFT;
                end
            end else begin
                out_result <= alu_res;
                out_zero   <= (alu_res == '0);
                state      <= DONE;
            end
        end else begin
            case (state)
                SHIFT: begin
                    shreg <= shift_next;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        out_result <= shift_next;
                        out_zero   <= (shift_next == '0);
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUCt;
    logic        Sign;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;

    int n_total = 0;
    int n_bad   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUCt      (ALUCt),
        .Sign       (Sign),
        .in_a       (in_a),
        .in_b       (in_b),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one op, confirm it is accepted, leave bench in cycle c+1
    task automatic issue(input logic [4:0] op, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        ALUCt    = op;
        Sign     = sgn;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        issue(op, sgn, a, b);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, out_result, exp);
        chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp == 32'd0});
        step();
    endtask

    task automatic run_shift(input string tag, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        n = int'(a[4:0]);
        issue(op, 1'b0, a, b);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_busy_valid"}, {31'd0, out_valid}, 32'd0);
            step();
        end
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, out_result, exp);
        step();
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
        step();
    endtask

    logic [31:0] b2b_a [4] = '{32'd1, 32'd2, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] b2b_b [4] = '{32'd1, 32'd3, 32'd200, 32'd1};
    logic [31:0] b2b_e [4] = '{32'd2, 32'd5, 32'd300, 32'd0};

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ALUCt     = 5'd0;
        Sign      = 1'b0;
        in_a      = '0;
        in_b      = '0;

        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_zero", {31'd0, out_zero}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        step();

        run_op("add_ovf", 5'b00010, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        run_op("sub_zero", 5'b00110, 1'b1, 32'd5, 32'd5, 32'd0);
        run_op("dflt_add", 5'b11111, 1'b0, 32'd2, 32'd3, 32'd5);
        run_op("dflt_add2", 5'b01000, 1'b1, 32'd10, 32'd20, 32'd30);
        run_op("and", 5'b00000, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        run_op("or", 5'b00001, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34);
        run_op("nor", 5'b01100, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB);
        run_op("xor", 5'b01101, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34);
        run_op("slt_s", 5'b00111, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1);
        run_op("slt_u", 5'b00111, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0);

        run_shift("sra4", 5'b11001, 32'd4, 32'h8000_0010, 32'hF800_0001);
        run_shift("srl4", 5'b11000, 32'd4, 32'h8000_0010, 32'h0800_0001);
        run_shift("srl0", 5'b11000, 32'd0, 32'h0000_00A5, 32'h0000_00A5);
        run_shift("sll31", 5'b10000, 32'd31, 32'h0000_0001, 32'h8000_0000);

        // reset in cycle c+3 of a long SRA
        issue(5'b11001, 1'b0, 32'd20, 32'h8000_0000);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", out_result, 32'd0);
        chk("midrst_zero", {31'd0, out_zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        watch_no_valid("midrst_no_result", 25);

        // backpressure: hold the result for three cycles with a new op pending
        out_ready = 1'b0;
        issue(5'b00010, 1'b0, 32'd10, 32'd20);
        ALUCt    = 5'b00010;
        in_a     = b2b_a[0];
        in_b     = b2b_b[0];
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", out_result, 32'd30);
            chk("bp_zero", {31'd0, out_zero}, 32'd0);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            step();
        end

        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_a     = b2b_a[k];
            in_b     = b2b_b[k];
            in_valid = 1'b1;
            @(negedge clk);
            chk("b2b_ready", {31'd0, in_ready}, 32'd1);
            if (k > 0) begin
                chk("b2b_valid", {31'd0, out_valid}, 32'd1);
                chk("b2b_result", out_result, b2b_e[k-1]);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_last_result", out_result, b2b_e[3]);
        chk("b2b_last_zero", {31'd0, out_zero}, 32'd1);
        step();

        // flush in cycle c+2 of SLL n=8
        issue(5'b10000, 1'b0, 32'd8, 32'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ready_c3", {31'd0, in_ready}, 32'd1);
        chk("flush_result_kept", out_result, 32'd0);
        watch_no_valid("flush_no_result", 12);

        // flush coincident with a presented op
        ALUCt    = 5'b00010;
        in_a     = 32'd1;
        in_b     = 32'd2;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        watch_no_valid("flush_not_accepted", 3);

        run_op("post_flush_add", 5'b00010, 1'b0, 32'd3, 32'd4, 32'd7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 5-bit `ALUCt` operation code and `Sign` flag produced by the ALU control decoder, and returns a registered result over a valid/ready handshake. Logical, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, and stall upstream through `in_ready`. It sits between ID/EX operand delivery and the EX/MEM pipeline register.

## Interface
- `WIDTH`, 32: operand/result width; shift count is `in_a[4:0]`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit accepts the operation this cycle.
- `ALUCt`  in  5  operation code.
- `Sign`  in  1  signed (1) or unsigned (0) compare for SLT.
- `in_a`  in  WIDTH  operand A; shift amount in bits [4:0] for shifts.
- `in_b`  in  WIDTH  operand B; value to be shifted for shifts.
- `flush`  in  1  synchronous kill of in-flight op and pending output.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream consumes the result.
- `out_result`  out  WIDTH  registered result.
- `out_zero`  out  1  registered (`out_result == 0`).

## Operation
- Codes:
  - AND 00000: a&b.
  - OR 00001: a|b.
  - ADD 00010: a+b.
  - SUB 00110: a−b.
  - SLT 00111: 1 if a<b, else 0; signed if `Sign`=1, unsigned if 0.
  - NOR 01100: ~(a|b).
  - XOR 01101: a^b.
  - SLL 10000, SRL 11000, SRA 11001: shift b by a[4:0].
  - Any other code executes ADD.
- ADD/SUB wrap modulo 2^WIDTH. No overflow flag. `Sign` is ignored for everything except SLT.
- SRL fills with 0. SRA replicates b[WIDTH-1]. SLL fills with 0.
- Accept = `in_valid && in_ready` at a rising edge.
- `in_ready = !flush && (state==IDLE || (state==DONE && out_ready))`.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, accept non-shift: compute, load `out_result`/`out_zero`, go to DONE.
  - IDLE, accept shift with n=a[4:0]: load shift reg=b, cnt=n. n=0: go to DONE with result=b. n>0: go to SHIFT.
  - SHIFT: each edge shifts the register one bit and decrements cnt. The edge that makes cnt 0 loads the result and goes to DONE.
  - DONE, `out_ready`=1 with new accept: handle exactly as in IDLE (back-to-back).
  - DONE, `out_ready`=1 with no accept: go to IDLE.
  - DONE, `out_ready`=0: hold `out_result`, `out_zero`, `out_valid` stable.
- `out_valid` = (state==DONE).
- `flush`: next state IDLE, cnt cleared, no accept that cycle. `out_result`/`out_zero` keep their last values but `out_valid` drops. Flush wins over every simultaneous event except reset.
- Reset (asynchronous, any state, including mid-shift):
  - State IDLE, cnt 0.
  - `out_valid` 0, `out_result` 0, `out_zero` 1.
  - `in_ready` 1 once `flush` is low.

## Timing
- Latency is counted from the accept cycle c.
  - Non-shift and shift with n=0: `out_valid` high in cycle c+1.
  - Shift with n>0: `out_valid` high in cycle c+1+n. `in_ready` is low in cycles c+1 … c+n.
- Throughput: one non-shift op per cycle while `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready` and `flush` only. There is no combinational path from operands to outputs.

## Test plan
- **Reset:** start SRA with n=20, drive `reset` low in cycle c+3.
  - Immediately: `out_valid`=0, `out_result`=0, `out_zero`=1.
  - After release: `in_ready`=1; no result for the killed op ever appears.
- **ADD / SUB:**
  - ADD 0x7FFFFFFF+0x00000001 → cycle c+1: 0x80000000, zero=0.
  - SUB 5−5 → 0x00000000, zero=1.
  - ALUCt 5'b11111, a=2, b=3 → 0x00000005.
- **SLT:** a=0xFFFFFFFF, b=0x00000001.
  - `Sign`=1 → 0x00000001.
  - `Sign`=0 → 0x00000000.
- **Shifts:**
  - SRA a=4, b=0x80000010 → cycle c+5: 0xF8000001; `in_ready` low c+1..c+4.
  - SRL a=0, b=0xA5 → c+1: 0x000000A5.
  - SLL a=31, b=1 → c+32: 0x80000000.
- **Backpressure and back-to-back:**
  - Hold `out_ready`=0 for 3 cycles → result and `out_valid` stable, `in_ready`=0.
  - Then 4 consecutive ADDs with `out_ready`=1 → one result per cycle, in order.
- **Flush:**
  - Assert `flush` in cycle c+2 of SLL n=8 → `out_valid` never rises for that op; `in_ready`=1 in cycle c+3.
  - Flush coincident with `in_valid` → the op is not accepted.
